// File: rtl/mcbsp_frame_parser_pkg.sv
// Shared framing constants for the McBSP byte-stream parser and the transmit-side framer.
// Keeping them here lets both sides agree on the sync header, the length limit and the checksum width.
package mcbsp_frame_parser_pkg;

  typedef enum logic [2:0] {
    HUNT0   = 3'd0,
    HUNT1   = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CSUM    = 3'd4,
    DRAIN   = 3'd5
  } parseState_t;

  localparam logic [7:0] HDR0_DEFAULT    = 8'hEB;
  localparam logic [7:0] HDR1_DEFAULT    = 8'h90;
  localparam int         MAX_LEN_DEFAULT = 64;
  localparam int         CSUM_W          = 8;

  // Additive checksum, wrapping modulo 2**CSUM_W.
  function automatic logic [CSUM_W-1:0] csumAdd(input logic [CSUM_W-1:0] acc,
                                                input logic [7:0]        b);
    return acc + CSUM_W'(b);
  endfunction

endpackage

// File: rtl/mcbsp_frame_buf.sv
// Payload store: DEPTH x 8 register file, one synchronous write port and one asynchronous read port.
// No reset; contents are only read back after the parser has written them for the current frame.
module mcbsp_frame_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          interfaceClk,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [7:0]    wrData,
  input  logic [AW-1:0] rdAddr,
  output logic [7:0]    rdData
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge interfaceClk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/mcbsp_frame_parser.sv
// Hunts EB 90 sync, buffers len+payload, checks the additive checksum and replays good frames on valid/ready.
// Status pulses follow the causing strobe by one cycle; strobes arriving while a frame is being replayed are dropped.
module mcbsp_frame_parser
  import mcbsp_frame_parser_pkg::*;
#(
  parameter int         MAX_LEN = MAX_LEN_DEFAULT,
  parameter logic [7:0] HDR0    = HDR0_DEFAULT,
  parameter logic [7:0] HDR1    = HDR1_DEFAULT,
  parameter int         TIMEOUT = 1023
) (
  input  logic       interfaceClk,
  input  logic       nRst,
  input  logic       McBSPDataEn,
  input  logic [7:0] McBSPData,
  output logic [7:0] frameData,
  output logic       frameValid,
  input  logic       frameReady,
  output logic       frameSof,
  output logic       frameEof,
  output logic       frameGood,
  output logic       frameErr,
  output logic       frameDrop
);

  localparam int              PTR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int              TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

  parseState_t       state;
  parseState_t       stateNext;
  logic [7:0]        lenM1;
  logic [CSUM_W-1:0] sum;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  rdAddr;
  logic [TO_W-1:0]   toCnt;
  logic [7:0]        bufRdData;

  logic timedState;
  logic toExpire;
  logic accept;
  logic lastAccept;
  logic lenLoad;
  logic payloadWr;
  logic loadFirst;
  logic goodNext;
  logic errNext;
  logic dropNext;

  assign timedState = (state == HUNT1) || (state == LEN) ||
                      (state == PAYLOAD) || (state == CSUM);
  // Expiry is judged one cycle early so the abort lands on the edge where the count would hit TIMEOUT.
  assign toExpire   = timedState && !McBSPDataEn && (toCnt == TO_LAST);
  assign accept     = (state == DRAIN) && frameValid && frameReady;
  assign lastAccept = accept && frameEof;
  assign rdAddr     = loadFirst ? '0 : rdPtr + PTR_W'(1);

  mcbsp_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (PTR_W)
  ) uBuf (
    .interfaceClk (interfaceClk),
    .wrEn         (payloadWr),
    .wrAddr       (wrPtr),
    .wrData       (McBSPData),
    .rdAddr       (rdAddr),
    .rdData       (bufRdData)
  );

  always_ff @(posedge interfaceClk or negedge nRst) begin
    if (!nRst) begin
      state <= HUNT0;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    goodNext  = 1'b0;
    errNext   = 1'b0;
    dropNext  = 1'b0;
    lenLoad   = 1'b0;
    payloadWr = 1'b0;
    loadFirst = 1'b0;
    case (state)
      HUNT0: begin
        if (McBSPDataEn && (McBSPData == HDR0)) begin
          stateNext = HUNT1;
        end
      end
      HUNT1: begin
        // A repeated HDR0 may itself be the start of the real header.
        if (McBSPDataEn) begin
          if (McBSPData == HDR1) begin
            stateNext = LEN;
          end else if (McBSPData != HDR0) begin
            stateNext = HUNT0;
          end
        end
      end
      LEN: begin
        if (McBSPDataEn) begin
          if ((McBSPData == 8'd0) || (McBSPData > MAX_LEN_B)) begin
            errNext   = 1'b1;
            stateNext = HUNT0;
          end else begin
            lenLoad   = 1'b1;
            stateNext = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (McBSPDataEn) begin
          payloadWr = 1'b1;
          if (8'(wrPtr) == lenM1) begin
            stateNext = CSUM;
          end
        end
      end
      CSUM: begin
        if (McBSPDataEn) begin
          if (McBSPData == 8'(sum)) begin
            goodNext  = 1'b1;
            loadFirst = 1'b1;
            stateNext = DRAIN;
          end else begin
            errNext   = 1'b1;
            stateNext = HUNT0;
          end
        end
      end
      DRAIN: begin
        dropNext = McBSPDataEn;
        if (lastAccept) begin
          stateNext = HUNT0;
        end
      end
      default: stateNext = HUNT0;
    endcase
    if (toExpire) begin
      stateNext = HUNT0;
      errNext   = 1'b1;
    end
  end

  always_ff @(posedge interfaceClk or negedge nRst) begin
    if (!nRst) begin
      frameGood  <= 1'b0;
      frameErr   <= 1'b0;
      frameDrop  <= 1'b0;
      frameValid <= 1'b0;
      frameData  <= '0;
      frameSof   <= 1'b0;
      frameEof   <= 1'b0;
      toCnt      <= '0;
      lenM1      <= '0;
      sum        <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
    end else begin
      frameGood <= goodNext;
      frameErr  <= errNext;
      frameDrop <= dropNext;

      if (!timedState || toExpire || McBSPDataEn) begin
        toCnt <= '0;
      end else if (toCnt != TO_LIMIT) begin
        toCnt <= toCnt + TO_W'(1);
      end

      if (lenLoad) begin
        lenM1 <= McBSPData - 8'd1;
        sum   <= CSUM_W'(McBSPData);
        wrPtr <= '0;
      end else if (payloadWr) begin
        sum   <= csumAdd(sum, McBSPData);
        wrPtr <= wrPtr + PTR_W'(1);
      end

      // frameData always holds the byte at rdPtr; the read port already looks one ahead.
      if (loadFirst) begin
        frameValid <= 1'b1;
        frameData  <= bufRdData;
        frameSof   <= 1'b1;
        frameEof   <= (lenM1 == 8'd0);
        rdPtr      <= '0;
      end else if (lastAccept) begin
        frameValid <= 1'b0;
        frameData  <= '0;
        frameSof   <= 1'b0;
        frameEof   <= 1'b0;
      end else if (accept) begin
        rdPtr     <= rdPtr + PTR_W'(1);
        frameData <= bufRdData;
        frameSof  <= 1'b0;
        frameEof  <= ((8'(rdPtr) + 8'd1) == lenM1);
      end
    end
  end

endmodule

// File: tb/tb_mcbsp_frame_parser.sv
// Directed bench: a stream-level model (header substring search + length/checksum arithmetic) is checked
// against the DUT every cycle, and literal expectations per scenario pin the model itself.
module tb_mcbsp_frame_parser;

  localparam int         MAX_LEN = 64;
  localparam int         TIMEOUT = 1023;
  localparam logic [7:0] HDR0    = 8'hEB;
  localparam logic [7:0] HDR1    = 8'h90;

  logic       interfaceClk = 1'b0;
  logic       nRst;
  logic       McBSPDataEn;
  logic [7:0] McBSPData;
  logic [7:0] frameData;
  logic       frameValid;
  logic       frameReady;
  logic       frameSof;
  logic       frameEof;
  logic       frameGood;
  logic       frameErr;
  logic       frameDrop;

  always #5 interfaceClk = ~interfaceClk;

  mcbsp_frame_parser #(
    .MAX_LEN (MAX_LEN),
    .HDR0    (HDR0),
    .HDR1    (HDR1),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .interfaceClk (interfaceClk),
    .nRst         (nRst),
    .McBSPDataEn  (McBSPDataEn),
    .McBSPData    (McBSPData),
    .frameData    (frameData),
    .frameValid   (frameValid),
    .frameReady   (frameReady),
    .frameSof     (frameSof),
    .frameEof     (frameEof),
    .frameGood    (frameGood),
    .frameErr     (frameErr),
    .frameDrop    (frameDrop)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } beat_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         lastEdge = 0;
  int         goodCnt = 0;
  int         errCnt = 0;
  int         dropCnt = 0;
  beat_t      expQ[$];
  logic [7:0] hist[$];
  logic [7:0] accepted[$];
  logic [7:0] want[$];
  logic [7:0] seq[$];
  bit         expGood[int];
  bit         expErr[int];
  bit         expDrop[int];

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkN(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stream-level view: a frame starts at the first EB 90 in the bytes seen since the last frame ended.
  function automatic void modelByte(input logic [7:0] b, input int e);
    int         hdr;
    int         len;
    logic [7:0] s;
    logic       keep;
    beat_t      bt;
    lastEdge = e;
    if (expQ.size() > 0) begin
      expDrop[e] = 1'b1;
      return;
    end
    hist.push_back(b);
    hdr = -1;
    for (int i = 0; i + 1 < hist.size(); i++) begin
      if (hdr < 0 && hist[i] == HDR0 && hist[i+1] == HDR1) hdr = i;
    end
    if (hdr < 0) begin
      keep = (hist[$] == HDR0);
      hist.delete();
      if (keep) hist.push_back(HDR0);
      return;
    end
    for (int i = 0; i < hdr; i++) void'(hist.pop_front());
    if (hist.size() < 3) return;
    len = int'(hist[2]);
    if (len == 0 || len > MAX_LEN) begin
      expErr[e] = 1'b1;
      hist.delete();
      return;
    end
    if (hist.size() < len + 4) return;
    s = 8'h00;
    for (int i = 2; i < len + 3; i++) s += hist[i];
    if (s == hist[len+3]) begin
      expGood[e] = 1'b1;
      for (int i = 0; i < len; i++) begin
        bt.d   = hist[i+3];
        bt.sof = (i == 0);
        bt.eof = (i == len - 1);
        expQ.push_back(bt);
      end
    end else begin
      expErr[e] = 1'b1;
    end
    hist.delete();
  endfunction

  always @(posedge interfaceClk) cyc <= cyc + 1;

  // Outputs here reflect edge number cyc; inputs visible now are sampled at edge cyc+1.
  always @(negedge interfaceClk) begin
    if (!nRst) begin
      chk1("rst_valid", frameValid, 1'b0);
      chk8("rst_data", frameData, 8'h00);
      chk1("rst_sof", frameSof, 1'b0);
      chk1("rst_eof", frameEof, 1'b0);
      chk1("rst_good", frameGood, 1'b0);
      chk1("rst_err", frameErr, 1'b0);
      chk1("rst_drop", frameDrop, 1'b0);
      expQ.delete();
      hist.delete();
      expGood.delete();
      expErr.delete();
      expDrop.delete();
    end else begin
      chk1("good_pulse", frameGood, expGood.exists(cyc) != 0);
      chk1("err_pulse", frameErr, expErr.exists(cyc) != 0);
      chk1("drop_pulse", frameDrop, expDrop.exists(cyc) != 0);
      chk1("valid", frameValid, expQ.size() > 0);
      if (frameValid && expQ.size() > 0) begin
        chk8("data", frameData, expQ[0].d);
        chk1("sof", frameSof, expQ[0].sof);
        chk1("eof", frameEof, expQ[0].eof);
      end
      if (frameGood) goodCnt++;
      if (frameErr) errCnt++;
      if (frameDrop) dropCnt++;
      if (McBSPDataEn) begin
        modelByte(McBSPData, cyc + 1);
      end else if (hist.size() > 0 && expQ.size() == 0 && (cyc + 1 - lastEdge) == TIMEOUT) begin
        expErr[cyc+1] = 1'b1;
        hist.delete();
      end
      if (frameValid && frameReady) begin
        accepted.push_back(frameData);
        if (expQ.size() > 0) void'(expQ.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge interfaceClk);
      #1;
    end
  endtask

  task automatic sendSeq();
    foreach (seq[i]) begin
      McBSPDataEn = 1'b1;
      McBSPData   = seq[i];
      @(posedge interfaceClk);
      #1;
    end
    McBSPDataEn = 1'b0;
    McBSPData   = 8'h00;
  endtask

  task automatic clrCnt();
    goodCnt = 0;
    errCnt  = 0;
    dropCnt = 0;
    accepted.delete();
  endtask

  task automatic chkAccepted(input string nm);
    chkN({nm, "_count"}, accepted.size(), want.size());
    for (int i = 0; i < want.size() && i < accepted.size(); i++) chk8(nm, accepted[i], want[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       pat[6];
    logic [7:0] s;
    logic [7:0] d;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    nRst = 1'b1; McBSPDataEn = 1'b0; McBSPData = 8'h00; frameReady = 1'b1;
    #1 nRst = 1'b0;
    #2;
    chk1("reset_valid", frameValid, 1'b0);
    chk8("reset_data", frameData, 8'h00);
    chk1("reset_good", frameGood, 1'b0);
    chk1("reset_err", frameErr, 1'b0);
    chk1("reset_drop", frameDrop, 1'b0);
    idle(2);
    nRst = 1'b1;
    idle(2);

    // Good frame, sink always ready
    clrCnt();
    seq = '{8'hEB, 8'h90, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    sendSeq();
    chk1("good_pulse_now", frameGood, 1'b1);
    chk1("good_sof_now", frameSof, 1'b1);
    chk8("good_first_now", frameData, 8'h11);
    idle(6);
    chkN("good_goodcnt", goodCnt, 1);
    chkN("good_errcnt", errCnt, 0);
    want = '{8'h11, 8'h22, 8'h33};
    chkAccepted("good_bytes");

    // Backpressure 1,0,0,1,0,1
    clrCnt();
    sendSeq();
    for (int i = 0; i < 6; i++) begin
      frameReady = pat[i];
      idle(1);
      if (i == 1) chk8("bp_hold_data", frameData, 8'h22);
      if (i == 4) chk1("bp_hold_eof", frameEof, 1'b1);
    end
    idle(3);
    chkN("bp_goodcnt", goodCnt, 1);
    chkAccepted("bp_bytes");

    // Bad checksum, then a normal frame
    clrCnt();
    seq = '{8'hEB, 8'h90, 8'h02, 8'hAA, 8'h55, 8'h00};
    sendSeq();
    chk1("bad_err_now", frameErr, 1'b1);
    idle(1);
    chk1("bad_err_once", frameErr, 1'b0);
    chk1("bad_no_valid", frameValid, 1'b0);
    seq = '{8'hEB, 8'h90, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    sendSeq();
    idle(5);
    chkN("bad_errcnt", errCnt, 1);
    chkN("bad_goodcnt", goodCnt, 1);
    chkAccepted("bad_next_bytes");

    // Repeated first header byte, single-byte payload
    clrCnt();
    frameReady = 1'b0;
    seq = '{8'hEB, 8'hEB, 8'h90, 8'h01, 8'h7F, 8'h80};
    sendSeq();
    chk8("len1_data", frameData, 8'h7F);
    chk1("len1_sof", frameSof, 1'b1);
    chk1("len1_eof", frameEof, 1'b1);
    frameReady = 1'b1;
    idle(3);
    chkN("len1_goodcnt", goodCnt, 1);
    want = '{8'h7F};
    chkAccepted("len1_bytes");

    // Zero and oversize lengths
    clrCnt();
    seq = '{8'hEB, 8'h90, 8'h00};
    sendSeq();
    chk1("len0_err", frameErr, 1'b1);
    seq = '{8'hEB, 8'h90, 8'h41};
    sendSeq();
    chk1("len65_err", frameErr, 1'b1);
    idle(3);
    chkN("len_errcnt", errCnt, 2);
    chkN("len_goodcnt", goodCnt, 0);

    // Maximum length frame with random backpressure
    clrCnt();
    seq = '{8'hEB, 8'h90, 8'(MAX_LEN)};
    want.delete();
    s = 8'(MAX_LEN);
    for (int i = 0; i < MAX_LEN; i++) begin
      d = 8'(i * 7 + 3);
      seq.push_back(d);
      want.push_back(d);
      s += d;
    end
    seq.push_back(s);
    sendSeq();
    for (int i = 0; i < 150; i++) begin
      frameReady = 1'($urandom_range(0, 1));
      idle(1);
    end
    frameReady = 1'b1;
    idle(80);
    chkN("max_goodcnt", goodCnt, 1);
    chkAccepted("max_bytes");
    chk8("max_last", (accepted.size() == MAX_LEN) ? accepted[MAX_LEN-1] : 8'h00, 8'hBC);

    // Inter-byte timeout inside the payload
    clrCnt();
    seq = '{8'hEB, 8'h90, 8'h04, 8'h01};
    sendSeq();
    idle(TIMEOUT - 1);
    chk1("to_early", frameErr, 1'b0);
    idle(1);
    chk1("to_fire", frameErr, 1'b1);
    idle(2);
    seq = '{8'hEB, 8'h90, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    sendSeq();
    idle(5);
    chkN("to_errcnt", errCnt, 1);
    chkN("to_goodcnt", goodCnt, 1);
    want = '{8'h11, 8'h22, 8'h33};
    chkAccepted("to_next_bytes");

    // Overrun while the replay is stalled
    clrCnt();
    frameReady = 1'b0;
    seq = '{8'hEB, 8'h90, 8'h02, 8'h05, 8'h06, 8'h0D};
    sendSeq();
    seq = '{8'hEB, 8'h90, 8'h01, 8'h7F, 8'h80};
    sendSeq();
    idle(1);
    chkN("ovr_dropcnt", dropCnt, 5);
    chk8("ovr_hold_data", frameData, 8'h05);
    chk1("ovr_hold_sof", frameSof, 1'b1);
    frameReady = 1'b1;
    idle(4);
    chkN("ovr_goodcnt", goodCnt, 1);
    chkN("ovr_errcnt", errCnt, 0);
    want = '{8'h05, 8'h06};
    chkAccepted("ovr_bytes");

    // Reset in the middle of a replay
    clrCnt();
    frameReady = 1'b0;
    seq = '{8'hEB, 8'h90, 8'h01, 8'h7F, 8'h80};
    sendSeq();
    idle(2);
    nRst = 1'b0;
    #1;
    chk1("mid_rst_valid", frameValid, 1'b0);
    chk8("mid_rst_data", frameData, 8'h00);
    chk1("mid_rst_sof", frameSof, 1'b0);
    chk1("mid_rst_eof", frameEof, 1'b0);
    idle(2);
    nRst = 1'b1;
    idle(3);
    chkN("mid_rst_goodcnt", goodCnt, 1);
    chkN("mid_rst_errcnt", errCnt, 0);
    chkN("mid_rst_dropcnt", dropCnt, 0);
    chkN("mid_rst_xfers", accepted.size(), 0);
    frameReady = 1'b1;
    sendSeq();
    idle(4);
    chkN("post_rst_goodcnt", goodCnt, 2);
    want = '{8'h7F};
    chkAccepted("post_rst_bytes");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mcbsp_frame_parser.md
# mcbsp_frame_parser

Byte-stream frame parser placed directly downstream of the McBSP 16-bit-to-8-bit receive stage. It consumes the byte strobe/data pair that stage produces and hunts for a two-byte sync header. It then reads a length byte and the payload, and checks an 8-bit additive checksum. Only frames that pass the checksum are replayed to the logging back end over a valid/ready byte interface; corrupt, oversize and stalled frames are discarded and flagged.

## Interface
Parameters:
- MAX_LEN, 64, maximum payload bytes (1..255); sets buffer depth
- HDR0, 8'hEB, first sync byte
- HDR1, 8'h90, second sync byte
- TIMEOUT, 1023, max clocks between bytes inside a frame before abort

Ports:
- interfaceClk  in  1  McBSP interface clock; all logic on rising edge
- nRst  in  1  reset, asynchronous, active-low
- McBSPDataEn  in  1  one-cycle byte strobe from receive stage
- McBSPData  in  8  byte, valid when McBSPDataEn=1
- frameData  out  8  payload byte to back end
- frameValid  out  1  frameData valid
- frameReady  in  1  back end accepts byte
- frameSof  out  1  with first payload byte
- frameEof  out  1  with last payload byte
- frameGood  out  1  one-cycle pulse, checksum matched
- frameErr  out  1  one-cycle pulse, frame aborted (bad length, checksum, timeout)
- frameDrop  out  1  one-cycle pulse per input byte discarded during DRAIN

## Operation
- States: HUNT0, HUNT1, LEN, PAYLOAD, CSUM, DRAIN.
- HUNT0: byte==HDR0 -> HUNT1; else stay.
- HUNT1: byte==HDR1 -> LEN; byte==HDR0 -> stay HUNT1; else -> HUNT0.
- LEN: store len; sum<=len. len==0 or len>MAX_LEN -> frameErr, HUNT0. Else -> PAYLOAD, wr_ptr<=0.
- PAYLOAD: write byte at wr_ptr, sum<=sum+byte (mod 256), wr_ptr++. After the len-th byte -> CSUM.
- CSUM: byte==sum -> frameGood, DRAIN, rd_ptr<=0. Else -> frameErr, HUNT0.
- DRAIN: present buffer[rd_ptr]. On frameValid&frameReady, rd_ptr++. Accepting byte len-1 -> HUNT0. Every input strobe in DRAIN is ignored and pulses frameDrop, including any header.
- Timeout: in HUNT1/LEN/PAYLOAD/CSUM, a counter clears on each strobe and increments otherwise. Reaching TIMEOUT -> frameErr, HUNT0. Counter is idle in HUNT0/DRAIN.
- Only one error pulse per aborted frame.
- Checksum covers the length byte plus the payload, excluding the header and the checksum byte itself.

## Timing
- Reset values: frameData=0, frameValid=0, frameSof=0, frameEof=0, frameGood=0, frameErr=0, frameDrop=0, state HUNT0, all counters 0. Buffer contents are undefined.
- Reset mid-frame or mid-drain: abort immediately with no pulse. First cycle after release is HUNT0.
- Status pulses are registered and fire in the cycle after the causing strobe is sampled (cycle t -> high in t+1 only).
- Checksum byte sampled at edge t:
  - frameGood high in t+1.
  - frameValid high from t+1 with buffer[0] and frameSof=1.
- Handshake:
  - frameData, frameSof and frameEof hold stable while frameValid=1 and frameReady=0.
  - After an accept, the next byte appears the following cycle (no bubble).
  - frameEof=1 with buffer[len-1]; for len=1, Sof and Eof are both 1.
  - frameValid drops in the cycle after the Eof accept.
- A frame whose drain finishes at edge t can start detection on a strobe at edge t+1.
- Widths:
  - wr_ptr/rd_ptr: clog2(MAX_LEN) bits.
  - Length compare: 8 bits.
  - Timeout counter: clog2(TIMEOUT+1) bits, saturating.

## Structure
- The shared package holds the state enum, HDR0/HDR1 defaults, the MAX_LEN default, and a checksum-width constant, so the transmit-side framer uses identical values.
- One sub-module, mcbsp_frame_buf: MAX_LEN x 8 register file with one synchronous write port and one asynchronous read port. frameData is registered from it in the parser.

## Test plan
- Good frame: EB 90 03 11 22 33 69 -> frameGood once. frameData 11,22,33 with Sof on 11 and Eof on 33, frameReady held 1. No frameErr.
- Backpressure: same frame, frameReady toggled 1,0,0,1,0,1 -> each byte held stable while stalled. Exactly 3 transfers, order preserved.
- Bad checksum: EB 90 02 AA 55 00 -> frameErr one cycle after the 00 strobe. frameValid never asserts. Next good frame is parsed normally.
- Header/length corner cases:
  - EB EB 90 01 7F 80 -> good frame carrying 7F.
  - EB 90 00 -> frameErr.
  - EB 90 41 with MAX_LEN=64 -> frameErr.
- Timeout and reset: EB 90 04 01 then 1023 idle cycles -> frameErr, HUNT0. Separately, assert nRst mid-DRAIN -> all outputs 0 at once, no pulses.
- Overrun: during DRAIN with frameReady=0, inject 5 strobes (including EB 90) -> 5 frameDrop pulses. Drain data is unchanged and no new frame starts.
